// File: rtl/add4_rr_sched.sv
// add4_rr_sched: round-robin arbiter sharing one external combinational adder
// between two requesters. Each granted request takes three cycles: grant
// (operands latched onto the adder), issue (sum captured and ack raised),
// response (ack dropped and transaction counted).
module add4_rr_sched #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             ack1,
  output logic [W:0]       res,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W:0]       add_sum,
  output logic             busy,
  output logic             last_grant,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [W:0]       res_q;
  logic [W-1:0]     add_a_q;
  logic [W-1:0]     add_b_q;
  logic             busy_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] txn_cnt_q;

  logic             grant_s;
  logic [W-1:0]     sel_a_s;
  logic [W-1:0]     sel_b_s;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // was not served last wins, which makes continuous contention alternate.
  always_comb begin
    grant_s = 1'b0;
    if (req0 && req1) begin
      grant_s = ~last_grant_q;
    end else if (req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_s = a0;
    sel_b_s = b0;
    if (grant_s) begin
      sel_a_s = a1;
      sel_b_s = b1;
    end else begin
      sel_a_s = a0;
      sel_b_s = b0;
    end
  end

  // Scheduler FSM; every output is driven straight from a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      res_q        <= {(W+1){1'b0}};
      add_a_q      <= {W{1'b0}};
      add_b_q      <= {W{1'b0}};
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      txn_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            add_a_q      <= sel_a_s;
            add_b_q      <= sel_b_s;
            last_grant_q <= grant_s;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          // The adder has had a full cycle to settle on the latched operands.
          res_q   <= add_sum;
          ack0_q  <= ~last_grant_q;
          ack1_q  <= last_grant_q;
          busy_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          txn_cnt_q <= txn_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign res        = res_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;
  assign txn_cnt    = txn_cnt_q;

endmodule

// File: tb/tb_add4_rr_sched.sv
// Directed bench for add4_rr_sched. The shared adder is modelled in the bench
// as a plain combinational add; outputs are sampled on the falling edge.
module tb_add4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1;
  logic [4:0] res;
  logic [3:0] add_a, add_b;
  logic [4:0] add_sum;
  logic       busy;
  logic       last_grant;
  logic [7:0] txn_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  add4_rr_sched #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .res(res), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .busy(busy), .last_grant(last_grant), .txn_cnt(txn_cnt)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  // Free-running cycle count used to measure ack spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait up to 10 falling edges for an ack; k is the edge count (11 = timeout).
  task automatic wait_ack(output int k);
    k = 11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction from requester idx; called on a falling edge.
  task automatic single(input bit idx, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_res, input logic [7:0] exp_cnt);
    int k;
    if (idx) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    wait_ack(k);
    chk("latency", k, 2);
    chk("ack_sel0", ack0, !idx);
    chk("ack_sel1", ack1, idx);
    chk("res", res, exp_res);
    chk("last_grant", last_grant, idx);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("ack_drop", {ack0, ack1}, 2'b00);
    chk("txn_cnt", txn_cnt, exp_cnt);
    chk("busy_end", busy, 1'b0);
  endtask

  initial begin
    int k;
    int prev;

    // Reset values
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
    #12;
    chk("rst_ack", {ack0, ack1}, 2'b00);
    chk("rst_res", res, 5'h00);
    chk("rst_add_a", add_a, 4'h0);
    chk("rst_add_b", add_b, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txn", txn_cnt, 8'h00);
    chk("rst_lg", last_grant, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add: 3 + 5
    single(1'b0, 4'h3, 4'h5, 5'h08, 8'd1);
    // Carry and maximum on requester 1
    single(1'b1, 4'hF, 4'h1, 5'h10, 8'd2);
    single(1'b1, 4'hF, 4'hF, 5'h1E, 8'd3);
    chk("hold_res", res, 5'h1E);
    chk("hold_add_a", add_a, 4'hF);

    // Fairness: both requests held for six transactions after a fresh reset
    do_reset();
    a0 = 4'h1; b0 = 4'h1; a1 = 4'h2; b1 = 4'h2;
    req0 = 1'b1; req1 = 1'b1;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      wait_ack(k);
      chk("fair_timeout", (k <= 10), 1'b1);
      chk("fair_ack0", ack0, (n % 2) == 0);
      chk("fair_ack1", ack1, (n % 2) == 1);
      chk("fair_res", res, ((n % 2) == 0) ? 5'h02 : 5'h04);
      if (n > 0) chk("fair_gap", cyc - prev, 3);
      prev = cyc;
      if (n == 5) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(negedge clk);
    chk("fair_txn", txn_cnt, 8'd6);

    // Operand change one cycle after the grant edge must not matter
    req0 = 1'b1; a0 = 4'h7; b0 = 4'h7;
    @(negedge clk);
    chk("opchg_busy", busy, 1'b1);
    a0 = 4'h0;
    wait_ack(k);
    chk("opchg_latency", k, 1);
    chk("opchg_ack0", ack0, 1'b1);
    chk("opchg_res", res, 5'h0E);
    req0 = 1'b0;
    @(negedge clk);
    chk("opchg_txn", txn_cnt, 8'd7);

    // Reset while in ISSUE aborts the transaction
    req1 = 1'b1; a1 = 4'h3; b1 = 4'h3;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack", {ack0, ack1}, 2'b00);
    chk("mid_res", res, 5'h00);
    chk("mid_busy_clr", busy, 1'b0);
    chk("mid_lg", last_grant, 1'b1);
    chk("mid_txn", txn_cnt, 8'h00);
    @(negedge clk);
    chk("mid_ack_held", {ack0, ack1}, 2'b00);
    req0 = 1'b1; a0 = 4'h4; b0 = 4'h2;
    rst_n = 1'b1;
    wait_ack(k);
    chk("post_latency", k, 2);
    chk("post_ack0", ack0, 1'b1);
    chk("post_ack1", ack1, 1'b0);
    chk("post_res", res, 5'h06);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("post_txn", txn_cnt, 8'd1);

    // Counter wrap over 256 transactions with varied operands
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ta, tb;
      ta = i[3:0];
      tb = i[7:4];
      single(i[0], ta, tb, {1'b0, ta} + {1'b0, tb}, (i + 1) & 8'hFF);
    end
    chk("wrap_txn", txn_cnt, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Acks must never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(ack0 && ack1)) else begin
        n_fail++;
        $error("FAIL ack_excl observed=%b%b expected=not both", ack0, ack1);
      end
    end
  end

endmodule

// File: doc/add4_rr_sched.md
Name: add4_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit ripple adder (a+b, 5-bit sum with carry-out) between two requesters.
- Each requester presents operands with a level request and receives a one-cycle ack plus the registered 5-bit result.
- Sits between the board-level operand sources (PMOD inputs, or internal producers) and the single shared adder instance; the adder stays purely combinational outside this block.

Parameters:
- W, 4, operand width; result width is W+1.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request, level.
- a0  input  W  requester 0 operand a.
- b0  input  W  requester 0 operand b.
- ack0  output  1  requester 0 completion pulse.
- req1  input  1  requester 1 request, level.
- a1  input  W  requester 1 operand a.
- b1  input  W  requester 1 operand b.
- ack1  output  1  requester 1 completion pulse.
- res  output  W+1  result of last completed add; bit W is carry-out.
- add_a  output  W  operand a to shared adder.
- add_b  output  W  operand b to shared adder.
- add_sum  input  W+1  sum from shared adder (combinational from add_a/add_b).
- busy  output  1  high in any state other than IDLE.
- last_grant  output  1  index of most recently granted requester.
- txn_cnt  output  CNT_W  count of completed transactions.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; ack0=ack1=0; res=0; add_a=add_b=0; busy=0; txn_cnt=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-transaction aborts it: no ack is issued and res is cleared.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE, neither req high: stay in IDLE.
- IDLE, at least one req high at edge E:
  - Grant selection: if only one req is high, grant it. If both are high, grant !last_grant.
  - Latch that requester's a/b into add_a/add_b.
  - Set last_grant to the granted index. Go to ISSUE.
- ISSUE:
  - At edge E+1, capture add_sum into res and set the granted ack high. Go to RESP.
- RESP:
  - The granted ack is high for exactly this one cycle; res is valid from this cycle on.
  - At edge E+2: ack returns to 0, txn_cnt increments, go to IDLE.
- Latency and throughput:
  - Request sampled at edge E gives ack high during the cycle after edge E+1 (2-edge latency).
  - Maximum throughput is one transaction per 3 cycles.
- Handshake rules:
  - req is sampled only in IDLE. Requests arriving during ISSUE or RESP wait and are not lost while held high.
  - A req still high when IDLE is re-entered counts as a new request. A requester wanting a single add drops req in the cycle ack is seen.
  - Operands only need to be valid at the grant edge; later changes on a0/b0/a1/b1 do not affect the in-flight add.
- Fairness: with both reqs held high continuously, grants alternate 0,1,0,1,… Neither requester waits more than one other transaction.
- Output holding:
  - res holds its value until the next ISSUE capture.
  - add_a/add_b hold the last granted operands while idle.
- Arithmetic: res = a + b, zero-extended to W+1 bits, no truncation. The maximum 4'hF+4'hF = 5'h1E.
- Counter: txn_cnt wraps from 2^CNT_W-1 to 0 without flagging.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- After reset, req0=1, a0=4'h3, b0=4'h5 → ack0 pulses 1 cycle at edge+2 with res=5'h08. ack1 stays 0, txn_cnt=1, last_grant=0.
- Carry and max case: req1 with a1=4'hF, b1=4'h1 → res=5'h10. Then a1=4'hF, b1=4'hF → res=5'h1E.
- Both reqs held high for 6 transactions (a0=1,b0=1; a1=2,b1=2) → acks in order 0,1,0,1,0,1.
  - res alternates 5'h02 and 5'h04.
  - Each ack is 3 cycles apart; txn_cnt=6.
- Operand change after grant: req0 with a0=4'h7, b0=4'h7, then a0 changed to 4'h0 one cycle after grant → res=5'h0E.
- Reset mid-op: assert rst_n=0 during ISSUE → no ack is issued, res=0, busy=0, last_grant=1. After release with both reqs high, requester 0 is granted first.
- Counter wrap: run 256 transactions → txn_cnt returns to 0 and res stays correct on the 256th add.
